mult_seq_nxn: RTL and testbench
===============================

# mult_seq_nxn

Parametrised sequential shift-add multiplier with operand registers loaded from a shared input bus and a start/busy/done handshake. Successor to the fixed 8x8 combinational multiplier: operand width is a parameter, the product is computed over N cycles with a single N-bit adder, and optional two's-complement mode is available. Sits between the switch/operand input logic and the product display path; `P` feeds the hex decoders unchanged.

## Interface
- `N`, 8: operand width in bits, 2..32; product width is 2N.
- `Clk` input 1: rising-edge clock.
- `Reset` input 1: asynchronous, active-low reset.
- `Input` input N: shared operand bus.
- `En_A` input 1: load `Input` into operand register A at the clock edge.
- `En_B` input 1: load `Input` into operand register B at the clock edge.
- `Start` input 1: request a multiply of the current A and B. Sampled only in IDLE.
- `Signed` input 1: two's-complement mode, sampled with `Start`. Present only with `MULT_SIGNED_EN`.
- `A_Q` output N: operand register A.
- `B_Q` output N: operand register B.
- `Busy` output 1: high whenever the state is not IDLE.
- `Done` output 1: one-cycle pulse when `P` is updated.
- `P` output 2N: last completed product, held until the next completion.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:** when `Start` is 1, capture working copies and go to RUN.
  - Working multiplicand M is 2N bits, zero-extended from A.
  - Working multiplier Q is N bits, from B.
  - Accumulator ACC is 2N bits, cleared to 0.
  - Iteration counter is cleared to 0.
  - With `Start` at 0, stay in IDLE.
- **RUN:** on each edge:
  - If Q[0] is 1, ACC <= ACC + M.
  - M shifts left by 1 and Q shifts right by 1.
  - The counter increments; after the Nth RUN edge, go to DONE.
- **DONE:** on the next edge, `P` <= ACC (sign-corrected if enabled) and the FSM returns to IDLE.
- `Done` is high for exactly the cycle after the P update, registered alongside `P`.
- **Operand registers:** A and B load independently, in any state.
  - With `En_A` and `En_B` both high, both registers load the same value.
  - Loading during Busy does not disturb the product in progress, which uses the working copies.
- **Start rules:**
  - If `Start` and `En_A` are high on the same edge, the multiply uses the old A. The same applies to B.
  - `Start` while Busy is ignored and not queued.
- **Arithmetic:**
  - All unsigned operations are modulo 2^2N. ACC cannot overflow for unsigned operands.
  - The maximum product is (2^N-1)^2.

## Timing
- Start is accepted at edge 0, RUN occupies edges 1..N, and `P`/`Done` update at edge N+1.
- `Done` is observed high during the cycle after edge N+1.
- Latency is N+1 edges.
- `Busy` is high after edge 0 through edge N+1, inclusive of the DONE cycle.
- Minimum start-to-start spacing is N+2 cycles. A new `Start` may be accepted at edge N+2, while `Done` is still high.
- **Reset assertion:** immediately, regardless of `Clk`:
  - state returns to IDLE;
  - A, B, `P`, ACC, M, Q and the counter clear to 0;
  - `Busy` and `Done` go to 0.
- **Reset mid-operation:** the result is abandoned and `P` stays 0.
- **Reset deassertion:** the first edge after deassertion may accept `Start`.

## Configuration
- **`MULT_SIGNED_EN` defined:**
  - The `Signed` port exists.
  - With `Signed` = 1 at Start, the working copies take the magnitude of A and B. A magnitude of 2^(N-1) is representable unsigned.
  - A negate flag is latched as A[N-1] XOR B[N-1].
  - At DONE, `P` <= negate ? -ACC : ACC, giving a 2N-bit two's-complement result.
  - Latency is unchanged.
  - With `Signed` = 0, behaviour is identical to the macro-absent build.
- **`MULT_SIGNED_EN` undefined:** the port is absent and all operands are unsigned.

## Structure
- **Package `mult_pkg`:**
  - state typedef (IDLE/RUN/DONE);
  - `MULT_N_DEFAULT` = 8;
  - counter width function clog2(N+1).
- **Sub-module `mult_datapath`:**
  - holds M, Q, ACC, the adder and the negate logic;
  - is controlled by load/step/finish strobes from the FSM in the top level.
- The top level holds the FSM, counter, and operand and product registers.

## Test plan
- **Unsigned maximum** (N=8): load A=0xFF, B=0xFF, pulse Start -> `P`=0xFE01, `Done` high exactly once, 9 edges after Start.
- **Zero and identity:** A=0x00, B=0xA5 -> `P`=0x0000; then A=0x01, B=0xA5 -> `P`=0x00A5; `Busy` low after each DONE.
- **Signed** (`MULT_SIGNED_EN`, `Signed`=1):
  - 0xFD×0x05 (-3×5) -> `P`=0xFFF1;
  - 0x80×0x80 -> `P`=0x4000;
  - 0x80×0x7F -> `P`=0xC080.
- **Busy interlock:**
  - Start A=0x10, B=0x10; reload A=0x02 and pulse Start at edge 3 -> `P`=0x0100, no second `Done`.
  - Start at edge 10 with A=0x02, B=0x10 -> `P`=0x0020.
- **Reset mid-RUN:** assert `Reset` low at edge 4 of a 0xFF×0xFF operation -> `P`, `A_Q`, `B_Q`, `Busy` and `Done` are 0 at once; no `Done` after release.
- **Parameter sweep:** N=4 with 0xF×0xF -> `P`=0xE1 after 5 edges; N=16 with 0xFFFF×0x0002 -> `P`=0x0001FFFE after 17 edges.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential multiplier.
// Holds the FSM state type, default width and counter sizing helper.
package mult_pkg;

    localparam int MULT_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// mult_datapath: working multiplicand/multiplier, accumulator and sign fix-up.
// Driven by load/step strobes from the mult_seq_nxn control FSM.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic           sgn,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod
);

    logic [2*N-1:0] m;
    logic [2*N-1:0] acc;
    logic [N-1:0]   q;
    logic           neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;

    // -2^(N-1) negates to itself, which reads correctly as an unsigned magnitude
    assign a_mag = (sgn && a[N-1]) ? -a : a;
    assign b_mag = (sgn && b[N-1]) ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            q   <= '0;
            acc <= '0;
            neg <= 1'b0;
        end else if (load) begin
            m   <= {{N{1'b0}}, a_mag};
            q   <= b_mag;
            acc <= '0;
            neg <= sgn && (a[N-1] ^ b[N-1]);
        end else if (step) begin
            if (q[0]) begin
                acc <= acc + m;
            end
            m <= m << 1;
            q <= q >> 1;
        end
    end

    assign prod = neg ? -acc : acc;

endmodule

// File: rtl/mult_seq_nxn.sv
// mult_seq_nxn: N-bit sequential shift-add multiplier, start/busy/done handshake.
// Define MULT_SIGNED_EN to add the Signed port and two's-complement mode.
module mult_seq_nxn
    import mult_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [N-1:0]   Input,
    input  logic           En_A,
    input  logic           En_B,
    input  logic           Start,
`ifdef MULT_SIGNED_EN
    input  logic           Signed,
`endif
    output logic [N-1:0]   A_Q,
    output logic [N-1:0]   B_Q,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] P
);

    localparam int CW = cnt_width(N);

    mult_state_t    state;
    mult_state_t    state_nxt;
    logic [CW-1:0]  cnt;
    logic           load;
    logic           step;
    logic           fin;
    logic           sgn;
    logic [2*N-1:0] prod;

`ifdef MULT_SIGNED_EN
    assign sgn = Signed;
`else
    assign sgn = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (Start) state_nxt = RUN;
            RUN:  if (cnt == CW'(N - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load = (state == IDLE) && Start;
        step = (state == RUN);
        fin  = (state == DONE);
        Busy = (state != IDLE);
    end

    // Operands load in any state; the datapath works on its own copies
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            A_Q  <= '0;
            B_Q  <= '0;
            cnt  <= '0;
            P    <= '0;
            Done <= 1'b0;
        end else begin
            if (En_A) A_Q <= Input;
            if (En_B) B_Q <= Input;
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CW'(1);
            end
            if (fin) P <= prod;
            Done <= fin;
        end
    end

    mult_datapath #(.N(N)) u_dp (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (load),
        .step  (step),
        .sgn   (sgn),
        .a     (A_Q),
        .b     (B_Q),
        .prod  (prod)
    );

endmodule

// File: tb/tb_mult_seq_nxn.sv
// tb_mult_seq_nxn: self-checking bench for mult_seq_nxn at N=4, 8 and 16.
// Signed cases are exercised when MULT_SIGNED_EN is defined.
module tb_mult_seq_nxn;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sgn = 1'b0;

    logic [3:0]  in4;
    logic        ena4, enb4, st4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  p4;

    logic [7:0]  in8;
    logic        ena8, enb8, st8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] p8;

    logic [15:0] in16;
    logic        ena16, enb16, st16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] p16;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mult_seq_nxn #(.N(4)) dut4 (
        .Clk(clk), .Reset(rst_n), .Input(in4), .En_A(ena4), .En_B(enb4),
        .Start(st4),
`ifdef MULT_SIGNED_EN
        .Signed(sgn),
`endif
        .A_Q(a4), .B_Q(b4), .Busy(busy4), .Done(done4), .P(p4)
    );

    mult_seq_nxn #(.N(8)) dut8 (
        .Clk(clk), .Reset(rst_n), .Input(in8), .En_A(ena8), .En_B(enb8),
        .Start(st8),
`ifdef MULT_SIGNED_EN
        .Signed(sgn),
`endif
        .A_Q(a8), .B_Q(b8), .Busy(busy8), .Done(done8), .P(p8)
    );

    mult_seq_nxn #(.N(16)) dut16 (
        .Clk(clk), .Reset(rst_n), .Input(in16), .En_A(ena16), .En_B(enb16),
        .Start(st16),
`ifdef MULT_SIGNED_EN
        .Signed(sgn),
`endif
        .A_Q(a16), .B_Q(b16), .Busy(busy16), .Done(done16), .P(p16)
    );

    // Reference: plain integer product reduced modulo 2^(2w)
    function automatic logic [31:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic sg);
        longint sa, sb, pr;
        logic [63:0] mask;
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
        if (sg) begin
            sa = (sa << (64 - w)) >>> (64 - w);
            sb = (sb << (64 - w)) >>> (64 - w);
        end
        pr = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 32'(64'(pr) & mask);
    endfunction

    task automatic drive(input int w, input logic [31:0] v, input logic ea,
                         input logic eb, input logic st);
        case (w)
            4:  begin in4 = v[3:0]; ena4 = ea; enb4 = eb; st4 = st; end
            16: begin in16 = v[15:0]; ena16 = ea; enb16 = eb; st16 = st; end
            default: begin in8 = v[7:0]; ena8 = ea; enb8 = eb; st8 = st; end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            4:  return done4;
            16: return done16;
            default: return done8;
        endcase
    endfunction

    function automatic logic [31:0] get_p(input int w);
        case (w)
            4:  return {24'b0, p4};
            16: return p16;
            default: return {16'b0, p8};
        endcase
    endfunction

    // Load A then B, pulse Start at edge 0, watch Done for a bounded window
    task automatic run(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, output logic [31:0] p, output int lat,
                       output int nd);
        drive(w, a, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(w, b, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        sgn = sg;
        drive(w, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(w, 0, 1'b0, 1'b0, 1'b0);
        lat = -1;
        nd = 0;
        p = '0;
        for (int k = 1; k <= w + 8; k++) begin
            @(posedge clk); #1;
            if (get_done(w)) begin
                nd++;
                if (lat < 0) begin
                    lat = k;
                    p = get_p(w);
                end
            end
        end
    endtask

    task automatic test_reset();
        drive(4, 0, 0, 0, 0);
        drive(8, 0, 0, 0, 0);
        drive(16, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({p8, a8, b8, busy8, done8} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset8 got p=%h a=%h b=%h busy=%b done=%b want all 0",
                     p8, a8, b8, busy8, done8);
        end
        tests_run++;
        if ({p4, p16, busy4, busy16} !== 42'd0) begin
            tests_failed++;
            $display("FAIL reset4_16 got p4=%h p16=%h want 0", p4, p16);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_max();
        logic [31:0] p;
        int lat, nd;
        run(8, 32'hFF, 32'hFF, 1'b0, p, lat, nd);
        tests_run++;
        if (p !== 32'hFE01) begin
            tests_failed++;
            $display("FAIL umax_p got %h want fe01", p);
        end
        tests_run++;
        if (lat !== 9 || nd !== 1) begin
            tests_failed++;
            $display("FAIL umax_timing got lat=%0d pulses=%0d want 9/1", lat, nd);
        end
    endtask

    task automatic test_zero_identity();
        logic [31:0] p;
        int lat, nd;
        run(8, 32'h00, 32'hA5, 1'b0, p, lat, nd);
        tests_run++;
        if (p !== 32'h0000 || lat !== 9 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero got p=%h lat=%0d busy=%b want 0/9/0", p, lat, busy8);
        end
        run(8, 32'h01, 32'hA5, 1'b0, p, lat, nd);
        tests_run++;
        if (p !== 32'h00A5 || lat !== 9 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL ident got p=%h lat=%0d busy=%b want a5/9/0", p, lat, busy8);
        end
    endtask

    task automatic test_random();
        logic [31:0] p, a, b, e;
        int lat, nd;
        for (int i = 0; i < 16; i++) begin
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            e = ref_mul(8, a, b, 1'b0);
            run(8, a, b, 1'b0, p, lat, nd);
            tests_run++;
            if (p !== e || lat !== 9 || nd !== 1) begin
                tests_failed++;
                $display("FAIL rand8 %h*%h got p=%h lat=%0d n=%0d want %h/9/1",
                         a, b, p, lat, nd, e);
            end
        end
    endtask

`ifdef MULT_SIGNED_EN
    task automatic test_signed();
        logic [31:0] p, a, b, e;
        logic [31:0] va [3] = '{32'hFD, 32'h80, 32'h80};
        logic [31:0] vb [3] = '{32'h05, 32'h80, 32'h7F};
        logic [31:0] ve [3] = '{32'hFFF1, 32'h4000, 32'hC080};
        int lat, nd;
        for (int i = 0; i < 3; i++) begin
            run(8, va[i], vb[i], 1'b1, p, lat, nd);
            tests_run++;
            if (p !== ve[i] || lat !== 9) begin
                tests_failed++;
                $display("FAIL signed_fixed %h*%h got %h lat=%0d want %h/9",
                         va[i], vb[i], p, lat, ve[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            e = ref_mul(8, a, b, 1'b1);
            run(8, a, b, 1'b1, p, lat, nd);
            tests_run++;
            if (p !== e) begin
                tests_failed++;
                $display("FAIL signed_rand %h*%h got %h want %h", a, b, p, e);
            end
        end
        sgn = 1'b0;
    endtask
`endif

    task automatic test_busy_interlock();
        int nd, lat;
        logic [31:0] p;
        drive(8, 32'h10, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        sgn = 1'b0;
        drive(8, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(8, 0, 1'b0, 1'b0, 1'b0);
        nd = 0;
        lat = -1;
        p = '0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) drive(8, 32'h02, 1'b1, 1'b0, 1'b1);
            @(posedge clk); #1;
            if (k == 3) drive(8, 0, 1'b0, 1'b0, 1'b0);
            if (done8) begin
                nd++;
                if (lat < 0) begin lat = k; p = get_p(8); end
            end
        end
        tests_run++;
        if (p !== 32'h0100 || lat !== 9 || nd !== 1 || a8 !== 8'h02) begin
            tests_failed++;
            $display("FAIL interlock got p=%h lat=%0d n=%0d a=%h want 0100/9/1/02",
                     p, lat, nd, a8);
        end
        // Start at edge 10 while Done is still high
        drive(8, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(8, 0, 1'b0, 1'b0, 1'b0);
        nd = 0;
        lat = -1;
        for (int k = 11; k <= 24; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                nd++;
                if (lat < 0) begin lat = k; p = get_p(8); end
            end
        end
        tests_run++;
        if (p !== 32'h0020 || lat !== 19 || nd !== 1) begin
            tests_failed++;
            $display("FAIL back_to_back got p=%h edge=%0d n=%0d want 0020/19/1",
                     p, lat, nd);
        end
    endtask

    task automatic test_reset_mid_run();
        int nd;
        drive(8, 32'hFF, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(8, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(8, 0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        tests_run++;
        if (busy8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_busy got %b want 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({p8, a8, b8, busy8, done8} !== 34'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset got p=%h a=%h b=%h busy=%b done=%b want 0",
                     p8, a8, b8, busy8, done8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done8) nd++;
        end
        tests_run++;
        if (nd !== 0 || p8 !== 16'h0 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset got pulses=%0d p=%h busy=%b want 0/0/0",
                     nd, p8, busy8);
        end
    endtask

    task automatic test_param_sweep();
        logic [31:0] p, a, b, e;
        int lat, nd;
        run(4, 32'hF, 32'hF, 1'b0, p, lat, nd);
        tests_run++;
        if (p !== 32'hE1 || lat !== 5 || nd !== 1) begin
            tests_failed++;
            $display("FAIL n4_max got p=%h lat=%0d n=%0d want e1/5/1", p, lat, nd);
        end
        run(16, 32'hFFFF, 32'h0002, 1'b0, p, lat, nd);
        tests_run++;
        if (p !== 32'h0001FFFE || lat !== 17 || nd !== 1) begin
            tests_failed++;
            $display("FAIL n16 got p=%h lat=%0d n=%0d want 1fffe/17/1", p, lat, nd);
        end
        for (int i = 0; i < 4; i++) begin
            a = 32'($urandom_range(0, 65535));
            b = 32'($urandom_range(0, 65535));
            e = ref_mul(16, a, b, 1'b0);
            run(16, a, b, 1'b0, p, lat, nd);
            tests_run++;
            if (p !== e || lat !== 17) begin
                tests_failed++;
                $display("FAIL n16_rand %h*%h got %h lat=%0d want %h/17",
                         a, b, p, lat, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_zero_identity();
        test_random();
`ifdef MULT_SIGNED_EN
        test_signed();
`endif
        test_busy_interlock();
        test_reset_mid_run();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
